// File: rtl/bcd_stopwatch_seconds.sv
// Seconds core of the stopwatch: a free-running prescaler that emits a one-cycle
// second tick, driving a two-digit BCD seconds counter (00-99, wraps to 00).
module bcd_stopwatch_seconds #(
   parameter int unsigned CLKS_PER_TICK = 10_000_000,
   parameter int unsigned CNT_W         = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       clear,
   output logic       second_tick,
   output logic [7:0] number
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);
   localparam int unsigned      N_DIGITS = 2;

   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                cnt_at_last;
   logic [N_DIGITS-1:0] digit_adv;

   assign cnt_at_last = (cnt_q == CNT_LAST);

   // A paused prescaler holds its value so partial-second progress survives.
   always_comb begin
      cnt_d = cnt_q;
      if (enable) begin
         cnt_d = cnt_at_last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign second_tick = enable & cnt_at_last & ~rst;

   // Ones advance on every tick; tens only when the ones digit rolls over.
   always_comb begin
      digit_adv    = '0;
      digit_adv[0] = second_tick;
      digit_adv[1] = second_tick & (number[3:0] >= 4'd9);
   end

   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         logic [3:0] digit_q;
         logic [3:0] digit_d;
         logic       digit_wrap;

         assign digit_wrap = (digit_q >= 4'd9);

         always_comb begin
            digit_d = digit_q;
            if (clear) begin
               digit_d = 4'd0;
            end else if (digit_adv[gi]) begin
               digit_d = digit_wrap ? 4'd0 : digit_q + 4'd1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               digit_q <= 4'd0;
            end else begin
               digit_q <= digit_d;
            end
         end

         assign number[gi*4 +: 4] = digit_q;
      end
   endgenerate

endmodule

// File: tb/tb_bcd_stopwatch_seconds.sv
// Bench for bcd_stopwatch_seconds with a short tick period: directed scenarios
// followed by random enable/clear/rst traffic, all compared to a seconds model.
module tb_bcd_stopwatch_seconds;

   localparam int CPT = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       clear = 1'b0;
   logic       second_tick;
   logic [7:0] number;

   int checks = 0;
   int failures = 0;

   // Reference model: enabled-cycle phase within the second, and elapsed seconds.
   int m_phase = 0;
   int m_secs = 0;
   int m_ticks = 0;
   int dut_ticks = 0;

   bcd_stopwatch_seconds #(
      .CLKS_PER_TICK(CPT),
      .CNT_W        (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clear      (clear),
      .second_tick(second_tick),
      .number     (number)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int s);
      logic [7:0] b;
      b[7:4] = 4'((s / 10) % 10);
      b[3:0] = 4'(s % 10);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check tick before the edge, update model, check number after.
   task automatic step(input logic r, input logic en, input logic clr);
      logic exp_tick;
      @(negedge clk);
      rst = r;
      enable = en;
      clear = clr;
      #1;
      exp_tick = en && !r && (m_phase == CPT - 1);
      chk("second_tick", {7'd0, second_tick}, {7'd0, exp_tick});
      if (second_tick === 1'b1) dut_ticks++;
      @(posedge clk);
      if (r) begin
         m_phase = 0;
         m_secs = 0;
      end else begin
         if (clr) m_secs = 0;
         else if (exp_tick) m_secs = (m_secs + 1) % 100;
         if (exp_tick) m_ticks++;
         if (en) m_phase = (m_phase + 1) % CPT;
      end
      #1;
      chk("number", number, to_bcd(m_secs));
   endtask

   task automatic run(input int n, input logic en);
      for (int i = 0; i < n; i++) step(1'b0, en, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0);
      m_ticks = 0;
      dut_ticks = 0;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("reset_number", number, 8'h00);
      $display("step reset: number=%h", number);

      // Count through 09->10, 19->20, up to 99 and wrap to 00
      run(40, 1'b1);
      chk("after_40_clks", number, 8'h10);
      run(40, 1'b1);
      chk("after_80_clks", number, 8'h20);
      run(316, 1'b1);
      chk("after_396_clks", number, 8'h99);
      chk("ticks_396", 8'(dut_ticks), 8'd99);
      run(4, 1'b1);
      chk("after_400_clks_wrap", number, 8'h00);
      chk("ticks_400", 8'(dut_ticks), 8'(m_ticks));
      $display("step wrap: number=%h ticks=%0d", number, dut_ticks);

      // Reset from a non-zero state
      run(6, 1'b1);
      do_reset();
      chk("rst_zeroes", number, 8'h00);
      $display("step rerst: number=%h", number);

      // Pause mid-period: progress held, first tick on 2nd enabled clock after resume
      run(2, 1'b1);
      run(10, 1'b0);
      chk("paused_no_tick", 8'(dut_ticks), 8'd0);
      chk("paused_number", number, 8'h00);
      run(1, 1'b1);
      chk("resume_1_no_tick", 8'(dut_ticks), 8'd0);
      run(1, 1'b1);
      chk("resume_2_tick", number, 8'h01);
      $display("step pause: number=%h ticks=%0d", number, dut_ticks);

      // Clear wins over a coincident tick; phase preserved
      do_reset();
      run(20, 1'b1);
      chk("pre_clear", number, 8'h05);
      run(3, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      chk("clear_on_tick", number, 8'h00);
      run(3, 1'b1);
      chk("post_clear_3", number, 8'h00);
      run(1, 1'b1);
      chk("post_clear_4", number, 8'h01);
      $display("step clear: number=%h", number);

      // rst and clear together mid-count
      run(6, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      m_ticks = 0;
      dut_ticks = 0;
      chk("rst_clear_number", number, 8'h00);
      run(3, 1'b1);
      chk("rst_clear_3_no_tick", 8'(dut_ticks), 8'd0);
      run(1, 1'b1);
      chk("rst_clear_4_tick", number, 8'h01);
      $display("step rst+clear: number=%h", number);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 49) == 0));
      end
      chk("random_ticks", 8'(dut_ticks), 8'(m_ticks));
      $display("step random: number=%h ticks=%0d", number, dut_ticks);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
